// File: rtl/counter_seq_pkg.sv
// Shared constants for counter_sequencer: FSM state encoding and the counter reload value.
package counter_seq_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  localparam int unsigned LOADVAL_ZERO = 0;

  // Control word driven into the counter instance each cycle.
  typedef struct packed {
    logic en;
    logic load;
  } cnt_ctrl_t;

  // en and load are mutually exclusive by construction; flag any overlap.
  function automatic logic ctrl_conflict(input cnt_ctrl_t c);
    return c.en & c.load;
  endfunction

endpackage

// File: rtl/counter_sequencer_counter.sv
// Up-counter with synchronous reset, enable and parallel load; enable has priority over load.
module counter_sequencer_counter #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned COUNT_START = 0,
  parameter int unsigned STEP        = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] loadval,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (en) begin
      count_d = count_q + WIDTH'(STEP);
    end else if (load) begin
      count_d = loadval;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= WIDTH'(COUNT_START);
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/counter_sequencer.sv
// Programmable interval timer: FSM driving one up-counter, one-shot/periodic, hold and abort.
// Optional prescaler is enabled by defining COUNTER_SEQ_PRESCALE_EN.
module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned PRESCALE   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  hold,
  input  logic                  oneshot,
  input  logic [DATA_WIDTH-1:0] period,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] count
);

  // Checked in every build so the prescaled and plain variants accept the same parameters.
  if (PRESCALE < 2) begin : g_prescale_check
    $error("PRESCALE must be >= 2");
  end

  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] period_q, period_d;
  logic                  oneshot_q, oneshot_d;
  cnt_ctrl_t             cnt_ctrl;
  logic [DATA_WIDTH-1:0] cnt_loadval;
  logic                  step;
  logic                  run_active;

  assign run_active = (state_q == ST_RUN) && !stop && !hold;

`ifdef COUNTER_SEQ_PRESCALE_EN
  localparam int unsigned PhaseW = $clog2(PRESCALE);

  logic [PhaseW-1:0] phase_q, phase_d;

  assign step = (phase_q == PhaseW'(PRESCALE - 1));

  always_comb begin
    phase_d = phase_q;
    if (state_q == ST_LOAD) begin
      phase_d = '0;
    end else if (run_active) begin
      phase_d = step ? '0 : phase_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end
`else
  assign step = 1'b1;
`endif

  always_comb begin
    state_d       = state_q;
    period_d      = period_q;
    oneshot_d     = oneshot_q;
    cnt_ctrl.en   = 1'b0;
    cnt_ctrl.load = 1'b0;
    cnt_loadval   = DATA_WIDTH'(LOADVAL_ZERO);
    done          = 1'b0;
    err           = 1'b0;

    if (stop) begin
      // Abort freezes the counter where it is.
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (period == '0) begin
              err = 1'b1;
            end else begin
              period_d  = period;
              oneshot_d = oneshot;
              state_d   = ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          cnt_ctrl.load = 1'b1;
          state_d       = ST_RUN;
        end
        ST_RUN: begin
          if (run_active && step) begin
            if (count != period_q) begin
              cnt_ctrl.en = 1'b1;
            end else begin
              done = 1'b1;
              if (oneshot_q) begin
                state_d = ST_IDLE;
              end else begin
                cnt_ctrl.load = 1'b1;
              end
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      period_q  <= '0;
      oneshot_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      period_q  <= period_d;
      oneshot_q <= oneshot_d;
    end
  end

  assign busy = (state_q == ST_LOAD) || (state_q == ST_RUN);

  counter_sequencer_counter #(
    .WIDTH      (DATA_WIDTH),
    .COUNT_START(0),
    .STEP       (1)
  ) u_counter (
    .clk    (clk),
    .rst    (rst),
    .en     (cnt_ctrl.en),
    .load   (cnt_ctrl.load),
    .loadval(cnt_loadval),
    .count  (count)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!ctrl_conflict(cnt_ctrl))
        else $error("counter en and load asserted together");
    end
  end

endmodule
